// File: rtl/p2_pkg.sv
// Shared types and constants for the P2 RAM arbiter slice.
// Holds the access FSM state enum, port ids and the RAM size.
package p2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      ACK  = 2'd3
   } state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_VID = 1'b1;

   localparam int RAM_BYTES = 524288;

endpackage

// File: rtl/p2_mem_arb_if.sv
// CPU, video and RAM bus bundle for p2_mem_arb.
// slave: arbiter view. master: requesters + RAM view.
interface p2_mem_arb_if #(
   parameter int ADDR_W = 23
) ();

   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_rw_n;
   logic [1:0]        cpu_be_n;
   logic [15:0]       cpu_wdata;
   logic              cpu_ack;
   logic [15:0]       cpu_rdata;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_ack;
   logic [15:0]       vid_rdata;

   logic              mem_go_n;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rw_n;
   logic              mem_wel_n;
   logic              mem_weu_n;
   logic [15:0]       mem_wdata;
   logic [15:0]       mem_rdata;

   modport slave (
      input  cpu_req, cpu_addr, cpu_rw_n,
      input  cpu_be_n, cpu_wdata,
      output cpu_ack, cpu_rdata,
      input  vid_req, vid_addr,
      output vid_ack, vid_rdata,
      output mem_go_n, mem_addr, mem_rw_n,
      output mem_wel_n, mem_weu_n, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_addr, cpu_rw_n,
      output cpu_be_n, cpu_wdata,
      input  cpu_ack, cpu_rdata,
      output vid_req, vid_addr,
      input  vid_ack, vid_rdata,
      input  mem_go_n, mem_addr, mem_rw_n,
      input  mem_wel_n, mem_weu_n, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/p2_arb_rr.sv
// 2-way grant picker: req[1:0] in, one-hot gnt[1:0] out, upd latches.
// Round-robin by default; P2_ARB_VIDEO_PRIO_EN gives video fixed priority.
module p2_arb_rr
   import p2_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

`ifdef P2_ARB_VIDEO_PRIO_EN

   assign gnt[PORT_VID] = req[PORT_VID];
   assign gnt[PORT_CPU] = req[PORT_CPU] & ~req[PORT_VID];

   logic unused_rr;
   assign unused_rr = &{1'b0, clk, reset_n, upd};

`else

   // port that won the previous access; the other one wins a tie
   logic last;

   assign gnt[PORT_CPU] = req[PORT_CPU] &
                          (~req[PORT_VID] | last);
   assign gnt[PORT_VID] = req[PORT_VID] &
                          (~req[PORT_CPU] | ~last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last <= PORT_VID;
      end else if (upd) begin
         last <= gnt[PORT_VID];
      end
   end

`endif

endmodule

// File: rtl/p2_mem_arb.sv
// Shares one RAM port between CPU and video; 4-cycle access sequence.
// Ports: clk, reset_n, bus (p2_mem_arb_if.slave). Option: P2_ARB_VIDEO_PRIO_EN.
module p2_mem_arb
   import p2_pkg::*;
#(
   parameter int ADDR_W = 23
) (
   input logic         clk,
   input logic         reset_n,
   p2_mem_arb_if.slave bus
);

   state_t            state;
   logic              win;
   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              upd;

   logic              go_n_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_n_q;
   logic              wel_n_q;
   logic              weu_n_q;
   logic [15:0]       wdata_q;
   logic              cpu_ack_q;
   logic              vid_ack_q;
   logic [15:0]       cpu_rdata_q;
   logic [15:0]       vid_rdata_q;

   assign req = {bus.vid_req, bus.cpu_req};
   assign upd = (state == IDLE) && (|req);

   p2_arb_rr u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .upd     (upd),
      .gnt     (gnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         win         <= PORT_CPU;
         go_n_q      <= 1'b1;
         addr_q      <= '0;
         rw_n_q      <= 1'b1;
         wel_n_q     <= 1'b1;
         weu_n_q     <= 1'b1;
         wdata_q     <= '0;
         cpu_ack_q   <= 1'b0;
         vid_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vid_rdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  state  <= CMD;
                  go_n_q <= 1'b0;
                  unique case (1'b1)
                     gnt[PORT_CPU]: begin
                        win     <= PORT_CPU;
                        addr_q  <= bus.cpu_addr;
                        rw_n_q  <= bus.cpu_rw_n;
                        // strobes only fall on writes
                        wel_n_q <= bus.cpu_rw_n | bus.cpu_be_n[0];
                        weu_n_q <= bus.cpu_rw_n | bus.cpu_be_n[1];
                        if (!bus.cpu_rw_n) begin
                           wdata_q <= bus.cpu_wdata;
                        end
                     end
                     gnt[PORT_VID]: begin
                        win     <= PORT_VID;
                        addr_q  <= bus.vid_addr;
                        rw_n_q  <= 1'b1;
                        wel_n_q <= 1'b1;
                        weu_n_q <= 1'b1;
                     end
                  endcase
               end
            end
            CMD: begin
               state <= DATA;
            end
            DATA: begin
               state   <= ACK;
               go_n_q  <= 1'b1;
               wel_n_q <= 1'b1;
               weu_n_q <= 1'b1;
               if (win == PORT_VID) begin
                  vid_ack_q <= 1'b1;
                  if (rw_n_q) begin
                     vid_rdata_q <= bus.mem_rdata;
                  end
               end else begin
                  cpu_ack_q <= 1'b1;
                  if (rw_n_q) begin
                     cpu_rdata_q <= bus.mem_rdata;
                  end
               end
            end
            ACK: begin
               state     <= IDLE;
               cpu_ack_q <= 1'b0;
               vid_ack_q <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_go_n  = go_n_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_rw_n  = rw_n_q;
   assign bus.mem_wel_n = wel_n_q;
   assign bus.mem_weu_n = weu_n_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.vid_ack   = vid_ack_q;
   assign bus.vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_p2_mem_arb.sv
// Scoreboard bench for p2_mem_arb: RAM model, reference memory,
// directed cases then randomized concurrent CPU/video traffic.
module tb_p2_mem_arb;
   import p2_pkg::*;

   typedef struct {
      bit          rd;
      logic [15:0] data;
   } exp_t;

   typedef struct {
      logic [22:0] addr;
      logic        rw_n;
      logic        wel;
      logic        weu;
      logic [15:0] wd;
   } acc_t;

`ifdef P2_ARB_VIDEO_PRIO_EN
   localparam int LAT_MAX = 64;
`else
   localparam int LAT_MAX = 8;
`endif

   logic clk = 1'b0;
   logic reset_n;

   int checks = 0;
   int errors = 0;

   exp_t cpu_q[$];
   exp_t vid_q[$];
   int   exp_order[$];
   bit   order_en = 1'b0;

   logic [15:0] ram[int];
   logic [15:0] ref_mem[int];

   acc_t last_acc;
   acc_t snap;
   int   run = 0;

   p2_mem_arb_if #(.ADDR_W(23)) bus ();

   p2_mem_arb #(.ADDR_W(23)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_rd(input logic [22:0] a);
      int k = int'(a[22:1]);
      return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
   endfunction

   function automatic void ref_wr(input logic [22:0] a,
                                  input logic [1:0] be_n,
                                  input logic [15:0] wd);
      logic [15:0] v = ref_rd(a);
      if (!be_n[0]) v[7:0] = wd[7:0];
      if (!be_n[1]) v[15:8] = wd[15:8];
      ref_mem[int'(a[22:1])] = v;
   endfunction

   // RAM model: command sampled on every edge while go_n is low
   always @(posedge clk) begin
      int k;
      k = int'(bus.mem_addr[22:1]);
      if (!bus.mem_go_n) begin
         if (!bus.mem_rw_n) begin
            logic [15:0] v;
            v = ram.exists(k) ? ram[k] : 16'h0000;
            if (!bus.mem_wel_n) v[7:0] = bus.mem_wdata[7:0];
            if (!bus.mem_weu_n) v[15:8] = bus.mem_wdata[15:8];
            ram[k] = v;
         end else begin
            bus.mem_rdata <= ram.exists(k) ? ram[k] : 16'h0000;
         end
      end
   end

   // ack monitor: pops the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (bus.cpu_ack && bus.vid_ack) begin
         chk("dual_ack", 2'b11, 2'b01);
      end
      if (bus.cpu_ack) begin
         chk("cpu_ack_expected", cpu_q.size() > 0, 1);
         if (cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            if (e.rd) chk("cpu_rdata", bus.cpu_rdata, e.data);
         end
         if (order_en) begin
            chk("order_cpu", exp_order.size() > 0 ?
                exp_order.pop_front() : -1, PORT_CPU);
         end
      end
      if (bus.vid_ack) begin
         chk("vid_ack_expected", vid_q.size() > 0, 1);
         if (vid_q.size() > 0) begin
            e = vid_q.pop_front();
            chk("vid_rdata", bus.vid_rdata, e.data);
         end
         if (order_en) begin
            chk("order_vid", exp_order.size() > 0 ?
                exp_order.pop_front() : -1, PORT_VID);
         end
      end
   end

   // RAM command monitor: go_n low exactly 2 cycles, fields stable
   always @(negedge clk) begin
      acc_t cur;
      cur.addr = bus.mem_addr;
      cur.rw_n = bus.mem_rw_n;
      cur.wel  = bus.mem_wel_n;
      cur.weu  = bus.mem_weu_n;
      cur.wd   = bus.mem_wdata;
      if (!reset_n) begin
         run = 0;
      end else if (!bus.mem_go_n) begin
         if (run == 0) begin
            snap = cur;
            last_acc = cur;
         end else begin
            chk("cmd_stable", {cur.addr, cur.rw_n, cur.wel,
                cur.weu, cur.wd},
                {snap.addr, snap.rw_n, snap.wel, snap.weu, snap.wd});
         end
         run++;
      end else if (run > 0) begin
         chk("go_n_low_cycles", run, 2);
         run = 0;
      end
   end

   task automatic cpu_op(input logic rw_n,
                         input logic [22:0] addr,
                         input logic [1:0] be_n,
                         input logic [15:0] wd,
                         input bit exact);
      exp_t e;
      int lat;
      bit got;
      @(negedge clk);
      e.rd = rw_n;
      e.data = ref_rd(addr);
      if (!rw_n) ref_wr(addr, be_n, wd);
      cpu_q.push_back(e);
      bus.cpu_addr = addr;
      bus.cpu_rw_n = rw_n;
      bus.cpu_be_n = be_n;
      bus.cpu_wdata = wd;
      bus.cpu_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 80) begin
         @(negedge clk);
         lat++;
         if (bus.cpu_ack) got = 1'b1;
      end
      bus.cpu_req = 1'b0;
      if (!got) chk("cpu_ack_timeout", 0, 1);
      else if (exact) chk("cpu_ack_latency", lat, 3);
      else chk("cpu_wait_bound", lat <= LAT_MAX, 1);
   endtask

   task automatic vid_op(input logic [22:0] addr,
                         input bit exact);
      exp_t e;
      int lat;
      bit got;
      @(negedge clk);
      e.rd = 1'b1;
      e.data = ref_rd(addr);
      vid_q.push_back(e);
      bus.vid_addr = addr;
      bus.vid_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 80) begin
         @(negedge clk);
         lat++;
         if (bus.vid_ack) got = 1'b1;
      end
      bus.vid_req = 1'b0;
      if (!got) chk("vid_ack_timeout", 0, 1);
      else if (exact) chk("vid_ack_latency", lat, 3);
      else chk("vid_wait_bound", lat <= LAT_MAX, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      for (int i = 0; i < 64; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         ram[(32'h40000 >> 1) + i] = v;
         ref_mem[(32'h40000 >> 1) + i] = v;
      end

      // reset with both requesters active
      reset_n = 1'b0;
      bus.cpu_req = 1'b1;
      bus.vid_req = 1'b1;
      bus.cpu_addr = 23'h40000;
      bus.cpu_rw_n = 1'b1;
      bus.cpu_be_n = 2'b11;
      bus.cpu_wdata = 16'h0;
      bus.vid_addr = 23'h40002;
      repeat (3) @(negedge clk);
      chk("rst_go_n", bus.mem_go_n, 1'b1);
      chk("rst_strobes", {bus.mem_weu_n, bus.mem_wel_n}, 2'b11);
      chk("rst_acks", {bus.cpu_ack, bus.vid_ack}, 2'b00);
      chk("rst_addr", bus.mem_addr, 23'h0);
      chk("rst_rdata", {bus.cpu_rdata, bus.vid_rdata}, 32'h0);

      // contention straight out of reset, held 16 cycles
`ifdef P2_ARB_VIDEO_PRIO_EN
      for (int i = 0; i < 4; i++) begin
         exp_order.push_back(PORT_VID);
         e.rd = 1'b1;
         e.data = ref_rd(23'h40002);
         vid_q.push_back(e);
      end
`else
      for (int i = 0; i < 4; i++) begin
         exp_order.push_back(i % 2 == 0 ? PORT_CPU : PORT_VID);
         e.rd = 1'b1;
         e.data = ref_rd(i % 2 == 0 ? 23'h40000 : 23'h40002);
         if (i % 2 == 0) cpu_q.push_back(e);
         else vid_q.push_back(e);
      end
`endif
      order_en = 1'b1;
      reset_n = 1'b1;
      repeat (16) @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.vid_req = 1'b0;
      order_en = 1'b0;
      chk("order_done", exp_order.size(), 0);
`ifdef P2_ARB_VIDEO_PRIO_EN
      cpu_q.delete();
`endif

      // word write then read
      cpu_op(1'b0, 23'h1000, 2'b00, 16'hBEEF, 1'b1);
      chk("wr_cmd", {last_acc.addr, last_acc.rw_n, last_acc.wel,
          last_acc.weu, last_acc.wd}, {23'h1000, 3'b000, 16'hBEEF});
      cpu_op(1'b1, 23'h1000, 2'b00, 16'h0, 1'b1);
      chk("rd_cmd", {last_acc.rw_n, last_acc.wel, last_acc.weu},
          3'b111);

      // lower-byte write
      cpu_op(1'b0, 23'h2000, 2'b10, 16'h12AB, 1'b1);
      chk("byte_strobes", {last_acc.wel, last_acc.weu}, 2'b01);
      cpu_op(1'b1, 23'h2000, 2'b00, 16'h0, 1'b1);

      // write with no bytes enabled
      cpu_op(1'b0, 23'h1000, 2'b11, 16'h0000, 1'b1);
      chk("nobe_strobes", {last_acc.wel, last_acc.weu}, 2'b11);
      cpu_op(1'b1, 23'h1000, 2'b00, 16'h0, 1'b1);

      // video fetch of CPU-written word
      cpu_op(1'b0, 23'h3FFFE, 2'b00, 16'h5A5A, 1'b1);
      vid_op(23'h3FFFE, 1'b1);
      chk("vid_cmd", {last_acc.addr, last_acc.rw_n, last_acc.wel,
          last_acc.weu}, {23'h3FFFE, 3'b111});

      // reset pulse in DATA aborts the access
      @(negedge clk);
      bus.cpu_addr = 23'h2800;
      bus.cpu_rw_n = 1'b0;
      bus.cpu_be_n = 2'b00;
      bus.cpu_wdata = 16'h7777;
      bus.cpu_req = 1'b1;
      repeat (2) @(negedge clk);
      chk("pre_abort_go_n", bus.mem_go_n, 1'b0);
      #2 reset_n = 1'b0;
      #1 chk("abort_go_n", bus.mem_go_n, 1'b1);
      bus.cpu_req = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ack", bus.cpu_ack, 1'b0);
      end
      chk("abort_rdata", bus.cpu_rdata, 16'h0);
      reset_n = 1'b1;
      cpu_op(1'b1, 23'h1000, 2'b00, 16'h0, 1'b1);

      // randomized concurrent traffic
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               cpu_op(1'($urandom_range(0, 1)),
                      23'(32'h4000 + 2 * $urandom_range(0, 31)),
                      2'($urandom_range(0, 3)),
                      16'($urandom), 1'b0);
            end
         end
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(1, 4)) @(negedge clk);
               vid_op(23'(32'h40000 + 2 * $urandom_range(0, 63)),
                      1'b0);
            end
         end
      join

      repeat (4) @(negedge clk);
      chk("cpu_q_empty", cpu_q.size(), 0);
      chk("vid_q_empty", vid_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
